// File: rtl/qea_run_sequencer.sv
// Host-side run controller for QEA: loads context, seeds |0..0>, starts, times, reads back.
// Latency: all outputs registered; one state RAM access per cycle. Result stream holds until i_res_ready.
module qea_run_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int CNT_WIDTH               = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]             i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]      i_ins_num,
    input  logic [CNT_WIDTH-1:0]                  i_timeout,
    input  logic                                  i_ctx_valid,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]    i_ctx_data,
    output logic                                  o_ctx_ready,
    output logic                                  o_res_valid,
    output logic [STATE_ADDR_WIDTH-1:0]           o_res_addr,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_res_data,
    input  logic                                  i_res_ready,
    output logic                                  o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]             o_qea_qbit_num,
    output logic                                  o_ctx_en,
    output logic                                  o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]    o_ctx_data,
    output logic                                  o_state_ena,
    output logic                                  o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]           o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_state_dina,
    input  logic                                  i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]    i_qea_state_dout,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_err_timeout,
    output logic                                  o_err_cfg,
    output logic [CNT_WIDTH-1:0]                  o_cycle_count
);

    localparam int SW   = PE_NUM * STATE_DATA_WIDTH;
    localparam int SAW  = STATE_ADDR_WIDTH;
    localparam int CAW  = GATE_CONTEXT_ADDR_WIDTH;

    localparam logic [MAX_QBIT_WIDTH-1:0] PNW_Q     = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] MAX_QBIT  = MAX_QBIT_WIDTH'(SAW + PE_NUM_WIDTH);
    localparam logic [CAW:0]              MAX_INS   = (CAW+1)'(1) << CAW;
    localparam logic [DATA_WIDTH-1:0]     ONE_FX    = DATA_WIDTH'(1) << NUM_FRAC_BIT;
    // Amplitude 1.0 for basis state 0 lives in the most significant lane.
    localparam logic [SW-1:0]             INIT_WORD = {ONE_FX, {DATA_WIDTH{1'b0}},
                                                       {(PE_NUM-1)*STATE_DATA_WIDTH{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_CTX, S_INIT_STATE, S_START, S_RUN,
        S_READ_ISSUE, S_READ_WAIT, S_READ_HOLD, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0] qbit_q, qbit_d;
    logic [CAW:0]              ins_q, ins_d;
    logic [CNT_WIDTH-1:0]      timeout_q, timeout_d;
    logic [CAW:0]              ctx_cnt_q, ctx_cnt_d;
    logic [SAW-1:0]            word_q, word_d;
    logic                      first_run_q, first_run_d;
    logic [CNT_WIDTH-1:0]      cycle_q, cycle_d;
    logic                      err_to_q, err_to_d;
    logic                      err_cfg_q, err_cfg_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      start_q, start_d;
    logic                      ctx_rdy_q, ctx_rdy_d;
    logic                      ctx_en_q, ctx_en_d;
    logic [CAW-1:0]            ctx_addr_q, ctx_addr_d;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_dat_q, ctx_dat_d;
    logic                      st_ena_q, st_ena_d;
    logic                      st_wea_q, st_wea_d;
    logic [SAW-1:0]            st_addr_q, st_addr_d;
    logic [SW-1:0]             st_din_q, st_din_d;
    logic                      res_vld_q, res_vld_d;
    logic [SAW-1:0]            res_addr_q, res_addr_d;
    logic [SW-1:0]             res_dat_q, res_dat_d;

    logic [SAW:0]              n_words, n_words_m1;
    logic [SAW-1:0]            last_word;
    logic [CAW:0]              ins_m1;
    logic [CNT_WIDTH-1:0]      cycle_inc;
    logic                      cfg_bad;

    always_comb begin
        n_words = (SAW+1)'(1);
        if (qbit_q > PNW_Q) begin
            n_words = (SAW+1)'(1) << (qbit_q - PNW_Q);
        end
        n_words_m1 = n_words - (SAW+1)'(1);
        last_word  = n_words_m1[SAW-1:0];
        ins_m1     = ins_q - (CAW+1)'(1);
        cycle_inc  = (cycle_q == {CNT_WIDTH{1'b1}}) ? cycle_q : cycle_q + CNT_WIDTH'(1);
        cfg_bad    = (i_qbit_num > MAX_QBIT) || (i_ins_num > MAX_INS);
    end

    always_comb begin
        state_d     = state_q;
        qbit_d      = qbit_q;
        ins_d       = ins_q;
        timeout_d   = timeout_q;
        ctx_cnt_d   = ctx_cnt_q;
        word_d      = word_q;
        first_run_d = first_run_q;
        cycle_d     = cycle_q;
        err_to_d    = err_to_q;
        err_cfg_d   = 1'b0;
        done_d      = 1'b0;
        start_d     = 1'b0;
        ctx_rdy_d   = 1'b0;
        ctx_en_d    = 1'b0;
        ctx_addr_d  = '0;
        ctx_dat_d   = '0;
        st_ena_d    = 1'b0;
        st_wea_d    = 1'b0;
        st_addr_d   = '0;
        st_din_d    = '0;
        res_vld_d   = 1'b0;
        res_addr_d  = res_addr_q;
        res_dat_d   = res_dat_q;

        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    if (cfg_bad) begin
                        err_cfg_d = 1'b1;
                    end else begin
                        qbit_d    = i_qbit_num;
                        ins_d     = i_ins_num;
                        timeout_d = i_timeout;
                        ctx_cnt_d = '0;
                        cycle_d   = '0;
                        err_to_d  = 1'b0;
                        if (i_ins_num == '0) begin
                            state_d  = S_INIT_STATE;
                            word_d   = '0;
                            st_ena_d = 1'b1;
                            st_wea_d = 1'b1;
                            st_din_d = INIT_WORD;
                        end else begin
                            state_d   = S_LOAD_CTX;
                            ctx_rdy_d = 1'b1;
                        end
                    end
                end
            end
            S_LOAD_CTX: begin
                ctx_rdy_d = 1'b1;
                if (i_ctx_valid && ctx_rdy_q) begin
                    ctx_en_d   = 1'b1;
                    ctx_addr_d = ctx_cnt_q[CAW-1:0];
                    ctx_dat_d  = i_ctx_data;
                    ctx_cnt_d  = ctx_cnt_q + (CAW+1)'(1);
                    // Drop ready on the final word so the stream cannot overrun ins_num.
                    if (ctx_cnt_q == ins_m1) begin
                        ctx_rdy_d = 1'b0;
                        state_d   = S_INIT_STATE;
                        word_d    = '0;
                        st_ena_d  = 1'b1;
                        st_wea_d  = 1'b1;
                        st_din_d  = INIT_WORD;
                    end
                end
            end
            S_INIT_STATE: begin
                if (word_q == last_word) begin
                    state_d = S_START;
                    start_d = 1'b1;
                end else begin
                    word_d    = word_q + SAW'(1);
                    st_ena_d  = 1'b1;
                    st_wea_d  = 1'b1;
                    st_addr_d = word_q + SAW'(1);
                end
            end
            S_START: begin
                state_d     = S_RUN;
                first_run_d = 1'b1;
            end
            S_RUN: begin
                first_run_d = 1'b0;
                if (i_qea_complete && !first_run_q) begin
                    state_d   = S_READ_ISSUE;
                    word_d    = '0;
                    st_ena_d  = 1'b1;
                end else begin
                    cycle_d = cycle_inc;
                    if ((timeout_q != '0) && (cycle_inc == timeout_q)) begin
                        err_to_d = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_READ_ISSUE: begin
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                res_dat_d  = i_qea_state_dout;
                res_addr_d = word_q;
                res_vld_d  = 1'b1;
                state_d    = S_READ_HOLD;
            end
            S_READ_HOLD: begin
                res_vld_d = 1'b1;
                if (i_res_ready) begin
                    res_vld_d = 1'b0;
                    if (word_q == last_word) begin
                        state_d = S_DONE;
                    end else begin
                        word_d    = word_q + SAW'(1);
                        st_ena_d  = 1'b1;
                        st_addr_d = word_q + SAW'(1);
                        state_d   = S_READ_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            qbit_q      <= '0;
            ins_q       <= '0;
            timeout_q   <= '0;
            ctx_cnt_q   <= '0;
            word_q      <= '0;
            first_run_q <= 1'b0;
            cycle_q     <= '0;
            err_to_q    <= 1'b0;
            err_cfg_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            ctx_rdy_q   <= 1'b0;
            ctx_en_q    <= 1'b0;
            ctx_addr_q  <= '0;
            ctx_dat_q   <= '0;
            st_ena_q    <= 1'b0;
            st_wea_q    <= 1'b0;
            st_addr_q   <= '0;
            st_din_q    <= '0;
            res_vld_q   <= 1'b0;
            res_addr_q  <= '0;
            res_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            qbit_q      <= qbit_d;
            ins_q       <= ins_d;
            timeout_q   <= timeout_d;
            ctx_cnt_q   <= ctx_cnt_d;
            word_q      <= word_d;
            first_run_q <= first_run_d;
            cycle_q     <= cycle_d;
            err_to_q    <= err_to_d;
            err_cfg_q   <= err_cfg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_q     <= start_d;
            ctx_rdy_q   <= ctx_rdy_d;
            ctx_en_q    <= ctx_en_d;
            ctx_addr_q  <= ctx_addr_d;
            ctx_dat_q   <= ctx_dat_d;
            st_ena_q    <= st_ena_d;
            st_wea_q    <= st_wea_d;
            st_addr_q   <= st_addr_d;
            st_din_q    <= st_din_d;
            res_vld_q   <= res_vld_d;
            res_addr_q  <= res_addr_d;
            res_dat_q   <= res_dat_d;
        end
    end

    assign o_ctx_ready    = ctx_rdy_q;
    assign o_res_valid    = res_vld_q;
    assign o_res_addr     = res_addr_q;
    assign o_res_data     = res_dat_q;
    assign o_qea_start    = start_q;
    assign o_qea_qbit_num = qbit_q;
    assign o_ctx_en       = ctx_en_q;
    assign o_ctx_wea      = ctx_en_q;
    assign o_ctx_addr     = ctx_addr_q;
    assign o_ctx_data     = ctx_dat_q;
    assign o_state_ena    = st_ena_q;
    assign o_state_wea    = st_wea_q;
    assign o_state_addra  = st_addr_q;
    assign o_state_dina   = st_din_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err_timeout  = err_to_q;
    assign o_err_cfg      = err_cfg_q;
    assign o_cycle_count  = cycle_q;

endmodule

// File: tb/tb_qea_run_sequencer.sv
// Directed bench for qea_run_sequencer with a behavioural QEA (context/state RAMs, completion timer).
module tb_qea_run_sequencer;
    localparam int W = 256;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_run = 1'b0;
    logic [5:0]     i_qbit_num = '0;
    logic [16:0]    i_ins_num = '0;
    logic [31:0]    i_timeout = '0;
    logic           i_ctx_valid = 1'b0;
    logic [63:0]    i_ctx_data = '0;
    logic           o_ctx_ready;
    logic           o_res_valid;
    logic [15:0]    o_res_addr;
    logic [W-1:0]   o_res_data;
    logic           i_res_ready = 1'b0;
    logic           o_qea_start;
    logic [5:0]     o_qea_qbit_num;
    logic           o_ctx_en, o_ctx_wea;
    logic [15:0]    o_ctx_addr;
    logic [63:0]    o_ctx_data;
    logic           o_state_ena, o_state_wea;
    logic [15:0]    o_state_addra;
    logic [W-1:0]   o_state_dina;
    logic           i_qea_complete = 1'b0;
    logic [W-1:0]   i_qea_state_dout = '0;
    logic           o_busy, o_done, o_err_timeout, o_err_cfg;
    logic [31:0]    o_cycle_count;

    always #5 clk = ~clk;

    qea_run_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_qbit_num(i_qbit_num),
        .i_ins_num(i_ins_num), .i_timeout(i_timeout), .i_ctx_valid(i_ctx_valid),
        .i_ctx_data(i_ctx_data), .o_ctx_ready(o_ctx_ready), .o_res_valid(o_res_valid),
        .o_res_addr(o_res_addr), .o_res_data(o_res_data), .i_res_ready(i_res_ready),
        .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num), .o_ctx_en(o_ctx_en),
        .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_qea_complete(i_qea_complete),
        .i_qea_state_dout(i_qea_state_dout), .o_busy(o_busy), .o_done(o_done),
        .o_err_timeout(o_err_timeout), .o_err_cfg(o_err_cfg), .o_cycle_count(o_cycle_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ctx_pat(input int k);
        logic [31:0] v;
        v = 32'(k);
        return {32'hC0DE_0000 | v, ~v};
    endfunction

    function automatic logic [W-1:0] res_pat(input int i);
        logic [31:0] v;
        v = 32'(i);
        return {32'hA000_0000 | v, 32'h1111_0000 | v, 32'hB000_0000 | v, 32'h2222_0000 | v,
                32'hC000_0000 | v, 32'h3333_0000 | v, 32'hD000_0000 | v, 32'h4444_0000 | v};
    endfunction

    // |0..0>: re = 1.0 (Q2.30) in the top lane, everything else zero.
    logic [W-1:0] init_w = {32'h4000_0000, 224'h0};

    // Controls written only by the main sequence.
    int run_id = 0;
    int ctx_total = 0;
    bit complete_en = 1'b0;
    bit stall_en = 1'b0;

    // Per-run observations, owned by the model process.
    int last_id = 0;
    int ctx_idx, ctx_wr, ctx_err, init_cnt, init_err, rd_cnt, stall_rd, start_cnt;
    int res_idx, res_err, valid_seen, stall_n, hold_err, cd;
    logic [W-1:0] mem [16];

    always @(negedge clk) begin : qea_model
        if (run_id != last_id) begin
            last_id = run_id;
            ctx_idx = 0; ctx_wr = 0; ctx_err = 0; init_cnt = 0; init_err = 0;
            rd_cnt = 0; stall_rd = 0; start_cnt = 0; res_idx = 0; res_err = 0;
            valid_seen = 0; stall_n = 0; hold_err = 0; cd = 0;
        end
        // Context source with random bubbles; junk stays offered once the run's words are sent.
        if (ctx_idx < ctx_total) begin
            if ($urandom_range(0, 3) == 0) begin
                i_ctx_valid = 1'b0;
            end else begin
                i_ctx_valid = 1'b1;
                i_ctx_data  = ctx_pat(ctx_idx);
                if (o_ctx_ready) ctx_idx++;
            end
        end else begin
            i_ctx_valid = 1'b1;
            i_ctx_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        if (o_ctx_en) begin
            if (!o_ctx_wea || o_ctx_addr != 16'(ctx_wr) || o_ctx_data != ctx_pat(ctx_wr)) ctx_err++;
            ctx_wr++;
        end
        if (o_state_ena && o_state_wea) begin
            if (o_state_addra != 16'(init_cnt) || o_state_dina != ((init_cnt == 0) ? init_w : '0))
                init_err++;
            mem[o_state_addra[3:0]] = o_state_dina;
            init_cnt++;
        end
        if (o_state_ena && !o_state_wea) begin
            rd_cnt++;
            if (o_res_valid) stall_rd++;
            i_qea_state_dout = mem[o_state_addra[3:0]];
        end
        i_qea_complete = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) i_qea_complete = 1'b1;
        end
        if (o_qea_start) begin
            start_cnt++;
            if (complete_en) begin
                cd = 51;
                for (int i = 0; i < 16; i++) mem[i] = res_pat(i);
            end
        end
        if (o_res_valid) begin
            valid_seen++;
            if (stall_en && o_res_addr == 16'd2 && stall_n < 10) begin
                i_res_ready = 1'b0;
                stall_n++;
                if (o_res_data != res_pat(2)) hold_err++;
            end else begin
                i_res_ready = 1'b1;
                if (o_res_addr != 16'(res_idx) || o_res_data != res_pat(res_idx)) res_err++;
                res_idx++;
            end
        end else begin
            i_res_ready = 1'b0;
        end
    end

    task automatic run_cfg(input int qb, input int ins, input int to, input bit cen, input bit sen);
        run_id++;
        ctx_total   = ins;
        complete_en = cen;
        stall_en    = sen;
        i_qbit_num  = 6'(qb);
        i_ins_num   = 17'(ins);
        i_timeout   = 32'(to);
        i_run       = 1'b1;
        @(negedge clk);
        i_run       = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int n;
        n = 0;
        while (!o_done && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, o_done, 1);
        @(negedge clk);
        check({tag, "_done_1cyc"}, o_done, 0);
        check({tag, "_idle"}, o_busy, 0);
    endtask

    initial begin : main
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {o_busy, o_done, o_ctx_ready, o_res_valid, o_qea_start, o_ctx_en,
                           o_state_ena, o_err_timeout, o_err_cfg}, 0);
        check("rst_count", o_cycle_count, 0);
        check("rst_qbit", o_qea_qbit_num, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full run, stalled readback on word 2, and a run request while busy.
        run_cfg(4, 115, 0, 1'b1, 1'b1);
        check("A_busy", o_busy, 1);
        repeat (20) @(negedge clk);
        i_qbit_num = 6'd19;
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        check("A_busy_cfg", o_err_cfg, 0);
        wait_done(2000, "A");
        check("A_ctx_writes", ctx_wr, 115);
        check("A_ctx_err", ctx_err, 0);
        check("A_init_writes", init_cnt, 4);
        check("A_init_err", init_err, 0);
        check("A_start", start_cnt, 1);
        check("A_cycles", o_cycle_count, 50);
        check("A_res_words", res_idx, 4);
        check("A_res_err", res_err, 0);
        check("A_stall", stall_n, 10);
        check("A_hold_err", hold_err, 0);
        check("A_reads", rd_cnt, 4);
        check("A_stall_reads", stall_rd, 0);
        check("A_timeout", o_err_timeout, 0);
        check("A_qbit", o_qea_qbit_num, 4);

        // Timeout: completion never arrives.
        run_cfg(3, 3, 20, 1'b0, 1'b0);
        wait_done(500, "B");
        check("B_timeout", o_err_timeout, 1);
        check("B_cycles", o_cycle_count, 20);
        check("B_valid", valid_seen, 0);
        check("B_reads", rd_cnt, 0);
        check("B_init_writes", init_cnt, 2);
        check("B_ctx_writes", ctx_wr, 3);
        repeat (3) @(negedge clk);
        check("B_sticky", o_err_timeout, 1);

        // Rejected configurations.
        run_cfg(19, 1, 0, 1'b0, 1'b0);
        check("C_cfg_qbit", o_err_cfg, 1);
        check("C_cfg_busy", o_busy, 0);
        @(negedge clk);
        check("C_cfg_pulse", o_err_cfg, 0);
        run_cfg(4, 65537, 0, 1'b0, 1'b0);
        check("C_cfg_ins", o_err_cfg, 1);
        check("C_cfg_busy2", o_busy, 0);
        check("C_sticky", o_err_timeout, 1);

        // Largest legal config is accepted; async reset in the middle of the context load.
        @(negedge clk);
        run_cfg(18, 65536, 0, 1'b0, 1'b0);
        check("D_accept", {o_busy, o_err_cfg}, 2'b10);
        check("D_clr_timeout", o_err_timeout, 0);
        repeat (30) @(negedge clk);
        check("D_loading", o_ctx_ready, 1);
        rst_n = 1'b0;
        #1;
        check("D_async", {o_busy, o_ctx_ready, o_ctx_en, o_state_ena, o_done}, 0);
        check("D_async_qbit", o_qea_qbit_num, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Smallest state (one word), no context.
        run_cfg(2, 0, 0, 1'b1, 1'b0);
        wait_done(500, "E");
        check("E_ctx_writes", ctx_wr, 0);
        check("E_init_writes", init_cnt, 1);
        check("E_init_err", init_err, 0);
        check("E_res_words", res_idx, 1);
        check("E_res_err", res_err, 0);
        check("E_cycles", o_cycle_count, 50);

        // Clean full run after the reset.
        run_cfg(4, 10, 0, 1'b1, 1'b0);
        wait_done(1000, "F");
        check("F_ctx_writes", ctx_wr, 10);
        check("F_ctx_err", ctx_err, 0);
        check("F_res_words", res_idx, 4);
        check("F_res_err", res_err, 0);
        check("F_reads", rd_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected one");
        $fatal(1);
    end

endmodule
